mdsa_out_collector: RTL
=======================

MDSA_OUT_COLLECTOR -- requirements
Module: mdsa_out_collector

Interface
REQ-001 Parameter N, default 4, sorter matrix dimension; one frame is N*N elements.
REQ-002 Parameter DW, default 8, element width in bits.
REQ-003 Parameter IW, default $clog2(N*N), index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 output_enable  input  1  sorter output strobe; data_in is valid when high.
REQ-007 data_in  input  DW  sorted element from the sorter's data_out.
REQ-008 m_valid  output  1  readout element valid.
REQ-009 m_ready  input  1  downstream accepts the readout element.
REQ-010 m_data  output  DW  readout element.
REQ-011 m_index  output  IW  position of m_data within the frame, 0..N*N-1.
REQ-012 m_last  output  1  high with the element at index N*N-1.
REQ-013 sorted_ok  output  1  the captured frame is non-decreasing; meaningful only in DRAIN.
REQ-014 done  output  1  one-cycle pulse after the last readout handshake.
REQ-015 overflow  output  1  sticky error: a strobe arrived while the block was not capturing.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CAPTURE, DRAIN.
REQ-017 In IDLE, output_enable=1 SHALL write data_in to buf[0], set wr_ptr=1 and move to CAPTURE.
REQ-018 In CAPTURE, each cycle with output_enable=1 SHALL write data_in to buf[wr_ptr] and increment wr_ptr.
- Cycles with output_enable=0 hold state (gaps allowed).
REQ-019 When the write at index N*N-1 occurs, the FSM SHALL enter DRAIN on the next edge.
- Writes are done while in CAPTURE, or in IDLE if N*N=1.
- rd_ptr is set to 0 on that transition.
REQ-020 In DRAIN, m_valid SHALL be 1.
- m_data=buf[rd_ptr], m_index=rd_ptr, m_last=(rd_ptr==N*N-1).
- m_data is registered from the buffer so it is stable while m_valid=1 and m_ready=0.
REQ-021 A handshake (m_valid and m_ready) SHALL increment rd_ptr.
- The handshake with m_last=1 returns the FSM to IDLE and pulses done for exactly one cycle.
REQ-022 m_valid SHALL be 0 in IDLE and CAPTURE.
- Latency from the last capture to the first m_valid is exactly 1 cycle.
REQ-023 sorted_ok SHALL be computed on the fly during capture.
- It is set to 1 at frame start.
- It is cleared if any element compares unsigned less than the previous captured element.
- Equal elements keep it at 1.
REQ-024 output_enable=1 during DRAIN SHALL set overflow and SHALL NOT write the buffer or disturb the readout.
- overflow is cleared only by reset.
REQ-025 Pointers SHALL NOT wrap during a frame.
- wr_ptr and rd_ptr return to 0 only on frame start and DRAIN entry, respectively.
REQ-026 If a new strobe and the final readout handshake occur in the same cycle, overflow SHALL be set and the strobe is dropped.

Reset
REQ-027 Asserting rst SHALL, without waiting for a clock edge:
- set the FSM to IDLE;
- clear wr_ptr, rd_ptr, m_valid, m_last, m_index, m_data, done and overflow;
- set sorted_ok=0.
REQ-028 Reset asserted mid-CAPTURE or mid-DRAIN SHALL discard the partial frame.
- After release the block waits in IDLE for a fresh strobe.
- Buffer contents need not be cleared.

Structure
REQ-029 A shared package mdsa_pkg SHALL hold the state enum type (IDLE/CAPTURE/DRAIN) and default N and DW constants, reused by the sorter bench.
REQ-030 The buffer SHALL be a sub-module mdsa_frame_buf: N*N x DW, one synchronous write port, one registered read port, no reset on storage.

Verification
REQ-031 N=4, DW=8; stream 0..15 on consecutive strobes, m_ready=1 -> m_valid rises 1 cycle after the 16th capture; indices 0..15 in order; m_last at 15; done 1 cycle; sorted_ok=1.
REQ-032 Stream 3,5,5,2,... (16 values) -> sorted_ok=0 throughout DRAIN; data read back unchanged.
REQ-033 Strobes with 2-cycle gaps; m_ready toggles 1,0,0,1 -> all 16 elements delivered once each; m_data stable while stalled.
REQ-034 Assert output_enable for one cycle during DRAIN -> overflow=1 and stays 1; readout sequence unaffected; a second frame afterwards works with overflow still 1.
REQ-035 Assert rst after the 7th capture, then stream a full frame -> only the new frame's 16 values appear; m_index starts at 0.
REQ-036 Assert rst while m_valid=1 between clock edges -> m_valid drops immediately (asynchronously), before the next edge.

Source files
------------

// File: rtl/mdsa_pkg.sv
// Shared definitions for the MDSA sorter and its output collector:
// the default matrix dimension, the default element width and the collector state type.
package mdsa_pkg;

   localparam int unsigned MDSA_N  = 4;
   localparam int unsigned MDSA_DW = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } mdsa_state_t;

endpackage

// File: rtl/mdsa_frame_buf.sv
// Frame buffer: N*N x DW storage, one synchronous write port and one registered read port.
// The storage array has no reset. Only the read register is reset, so the readout data
// is cleared together with the rest of the collector.
module mdsa_frame_buf #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 8,
   parameter int unsigned IW = $clog2(N*N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [IW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [N*N];
   logic [DW-1:0] rdata_q;

   // Storage write port. The array is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read port. A read of the address being written returns the new data,
   // which only matters when a frame is a single element.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mdsa_out_collector.sv
// Collects one N*N frame from the sorter's output strobe and replays it downstream
// as a valid/ready stream.
// Stream handshake: m_valid is held high in DRAIN. m_data, m_index and m_last stay
// stable until a cycle where m_valid and m_ready are both high. That cycle transfers
// the element on the rising edge.
module mdsa_out_collector
   import mdsa_pkg::*;
#(
   parameter int unsigned N  = MDSA_N,
   parameter int unsigned DW = MDSA_DW,
   parameter int unsigned IW = $clog2(N*N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          output_enable,
   input  logic [DW-1:0] data_in,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [IW-1:0] m_index,
   output logic          m_last,
   output logic          sorted_ok,
   output logic          done,
   output logic          overflow,
   output mdsa_state_t   state_dbg
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N*N - 1);

   mdsa_state_t   state_q, state_d;
   logic [IW-1:0] wr_ptr_q, wr_ptr_d;
   logic [IW-1:0] rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] prev_q, prev_d;
   logic          sorted_q, sorted_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic          buf_we;
   logic [IW-1:0] buf_waddr;
   logic          buf_re;
   logic [DW-1:0] buf_rdata;

   // State and bookkeeping registers. All of them clear as soon as reset rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         prev_q   <= '0;
         sorted_q <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         prev_q   <= prev_d;
         sorted_q <= sorted_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic: capture strobes into the buffer, then drain it on handshakes.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      prev_d    = prev_q;
      sorted_d  = sorted_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      buf_we    = 1'b0;
      buf_waddr = wr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (output_enable) begin
               buf_we    = 1'b1;
               buf_waddr = '0;
               wr_ptr_d  = IW'(1);
               prev_d    = data_in;
               sorted_d  = 1'b1;
               if (LAST_IDX == '0) begin
                  state_d  = DRAIN;
                  rd_ptr_d = '0;
               end else begin
                  state_d  = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (output_enable) begin
               buf_we = 1'b1;
               prev_d = data_in;
               if (data_in < prev_q) sorted_d = 1'b0;
               // The pointer parks on the last index and is not incremented past it.
               if (wr_ptr_q == LAST_IDX) begin
                  state_d  = DRAIN;
                  rd_ptr_d = '0;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // A strobe in DRAIN is dropped. This includes the cycle of the final handshake.
            if (output_enable) ovf_d = 1'b1;
            if (m_ready) begin
               if (rd_ptr_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Fetch the element that will be presented next cycle. A stall re-reads the same address.
      buf_re = (state_d == DRAIN);
   end

   mdsa_frame_buf #(
      .N  (N),
      .DW (DW),
      .IW (IW)
   ) u_buf (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (buf_we),
      .waddr_i (buf_waddr),
      .wdata_i (data_in),
      .re_i    (buf_re),
      .raddr_i (rd_ptr_d),
      .rdata_o (buf_rdata)
   );

   assign m_valid   = (state_q == DRAIN);
   assign m_index   = rd_ptr_q;
   assign m_last    = m_valid && (rd_ptr_q == LAST_IDX);
   assign m_data    = buf_rdata;
   assign sorted_ok = sorted_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign state_dbg = state_q;

endmodule
